// File: rtl/bcd_cnt_pkg.sv
// Shared types and helpers for the BCD up/down counter slice.
// A digit is one 4-bit decade; codes above DIGIT_MAX are illegal and get recovered when counting.
package bcd_cnt_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_illegal_digit(input bcd_digit_t d);
        return (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with synchronous load, up/down step and carry/borrow out.
// Latency: q updates one CLK after load/cin; cout is combinational from q, dn and cin.
// Backpressure: none; the digit steps whenever cin is high and load is low.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       cin,
    input  logic       dn,
    input  logic       load,
    input  bcd_digit_t ld_dig,
    output bcd_digit_t q,
    output logic       cout
);

    bcd_digit_t q_nxt;
    logic       gen;

    // Illegal codes wrap to 0 with carry going up, but settle on 9 without borrow going down.
    always_comb begin
        q_nxt = q;
        gen   = 1'b0;
        if (!dn) begin
            if (q >= DIGIT_MAX) begin
                q_nxt = '0;
                gen   = 1'b1;
            end else begin
                q_nxt = q + 4'd1;
            end
        end else begin
            if (is_illegal_digit(q)) begin
                q_nxt = DIGIT_MAX;
            end else if (q == '0) begin
                q_nxt = DIGIT_MAX;
                gen   = 1'b1;
            end else begin
                q_nxt = q - 4'd1;
            end
        end
    end

    assign cout = cin & gen;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            q <= '0;
        end else if (load) begin
            q <= ld_dig;
        end else if (cin) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable DIGITS-decade BCD up/down counter with load, terminal count and RCOn; MATCH built only with BCD_CNT_MATCH_EN.
// Latency: Q one CLK after LOADn/CTENn; MAX_MIN, RCOn and MATCH are combinational.
// Backpressure: none; CTENn gates counting and RCOn feeds the next stage's CTENn.
module bcd_updown_counter
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS = 2
)(
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      LOADn,
    input  logic                      CTENn,
    input  logic                      U_Dn,
    input  logic [DIGIT_W*DIGITS-1:0] LD_INPUT,
    input  logic [DIGIT_W*DIGITS-1:0] CMP_VAL,
    output logic [DIGIT_W*DIGITS-1:0] Q,
    output logic                      MAX_MIN,
    output logic                      RCOn,
    output logic                      MATCH
);

    logic              load;
    logic [DIGITS:0]   step_chain;
    logic              all_nine;
    logic              all_zero;
    logic              unused_carry;

    assign load          = ~LOADn;
    assign step_chain[0] = ~CTENn;
    assign unused_carry  = step_chain[DIGITS];

    // Digit k steps only when every lower digit generates carry/borrow in this cycle.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .CLK    (CLK),
            .RSTn   (RSTn),
            .cin    (step_chain[k]),
            .dn     (U_Dn),
            .load   (load),
            .ld_dig (LD_INPUT[DIGIT_W*k +: DIGIT_W]),
            .q      (Q[DIGIT_W*k +: DIGIT_W]),
            .cout   (step_chain[k+1])
        );
    end

    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (Q[DIGIT_W*k +: DIGIT_W] != DIGIT_MAX) all_nine = 1'b0;
            if (Q[DIGIT_W*k +: DIGIT_W] != '0)        all_zero = 1'b0;
        end
    end

    assign MAX_MIN = U_Dn ? all_zero : all_nine;
    assign RCOn    = ~(MAX_MIN & ~CTENn);

`ifdef BCD_CNT_MATCH_EN
    assign MATCH = (Q == CMP_VAL);
`else
    logic unused_cmp;
    assign unused_cmp = ^CMP_VAL;
    assign MATCH      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS=2 plus a two-stage DIGITS=1 cascade).
module tb_bcd_updown_counter;

`ifdef BCD_CNT_MATCH_EN
    localparam bit MATCH_EN = 1'b1;
`else
    localparam bit MATCH_EN = 1'b0;
`endif

    logic       CLK;
    logic       RSTn;
    logic       LOADn;
    logic       CTENn;
    logic       U_Dn;
    logic [7:0] LD_INPUT;
    logic [7:0] CMP_VAL;
    logic [7:0] Q;
    logic       MAX_MIN;
    logic       RCOn;
    logic       MATCH;

    logic       c_loadn;
    logic       c_ctenn;
    logic [3:0] c_lo_q;
    logic [3:0] c_hi_q;
    logic       c_lo_mm;
    logic       c_hi_mm;
    logic       c_lo_rco;
    logic       c_hi_rco;
    logic       c_lo_match;
    logic       c_hi_match;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bcd_updown_counter #(.DIGITS(2)) dut (
        .CLK(CLK), .RSTn(RSTn), .LOADn(LOADn), .CTENn(CTENn), .U_Dn(U_Dn),
        .LD_INPUT(LD_INPUT), .CMP_VAL(CMP_VAL), .Q(Q),
        .MAX_MIN(MAX_MIN), .RCOn(RCOn), .MATCH(MATCH)
    );

    bcd_updown_counter #(.DIGITS(1)) c_lo (
        .CLK(CLK), .RSTn(RSTn), .LOADn(c_loadn), .CTENn(c_ctenn), .U_Dn(1'b0),
        .LD_INPUT(4'h0), .CMP_VAL(4'h0), .Q(c_lo_q),
        .MAX_MIN(c_lo_mm), .RCOn(c_lo_rco), .MATCH(c_lo_match)
    );

    bcd_updown_counter #(.DIGITS(1)) c_hi (
        .CLK(CLK), .RSTn(RSTn), .LOADn(c_loadn), .CTENn(c_lo_rco), .U_Dn(1'b0),
        .LD_INPUT(4'h0), .CMP_VAL(4'h0), .Q(c_hi_q),
        .MAX_MIN(c_hi_mm), .RCOn(c_hi_rco), .MATCH(c_hi_match)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        tick();
        RSTn = 1'b1;
        LOADn = 1'b0; LD_INPUT = 8'h55;
        tick();
        LOADn = 1'b1;
        total_cnt++; if (Q !== 8'h55) $display("FAIL reset_preload: Q=%h expected %h", Q, 8'h55); else pass_cnt++;
        @(posedge CLK); #2;
        RSTn = 1'b0; U_Dn = 1'b1; CTENn = 1'b0; CMP_VAL = 8'h00;
        #1;
        total_cnt++; if (Q !== 8'h00) $display("FAIL reset_async_q: Q=%h expected %h", Q, 8'h00); else pass_cnt++;
        total_cnt++; if (MAX_MIN !== 1'b1) $display("FAIL reset_maxmin_dn: MAX_MIN=%b expected 1", MAX_MIN); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b0) $display("FAIL reset_rcon_dn: RCOn=%b expected 0", RCOn); else pass_cnt++;
        total_cnt++; if (MATCH !== MATCH_EN) $display("FAIL reset_match: MATCH=%b expected %b", MATCH, MATCH_EN); else pass_cnt++;
        U_Dn = 1'b0;
        #1;
        total_cnt++; if (MAX_MIN !== 1'b0) $display("FAIL reset_maxmin_up: MAX_MIN=%b expected 0", MAX_MIN); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b1) $display("FAIL reset_rcon_up: RCOn=%b expected 1", RCOn); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h00) $display("FAIL reset_held: Q=%h expected %h", Q, 8'h00); else pass_cnt++;
        CTENn = 1'b1;
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_up_wrap();
        LOADn = 1'b0; CTENn = 1'b1; U_Dn = 1'b0; LD_INPUT = 8'h98;
        tick();
        LOADn = 1'b1; CTENn = 1'b0;
        #1;
        total_cnt++; if (Q !== 8'h98) $display("FAIL up_load: Q=%h expected %h", Q, 8'h98); else pass_cnt++;
        total_cnt++; if (MAX_MIN !== 1'b0) $display("FAIL up_98_maxmin: MAX_MIN=%b expected 0", MAX_MIN); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h99) $display("FAIL up_99: Q=%h expected %h", Q, 8'h99); else pass_cnt++;
        total_cnt++; if (MAX_MIN !== 1'b1) $display("FAIL up_99_maxmin: MAX_MIN=%b expected 1", MAX_MIN); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b0) $display("FAIL up_99_rcon: RCOn=%b expected 0", RCOn); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h00) $display("FAIL up_wrap: Q=%h expected %h", Q, 8'h00); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b1) $display("FAIL up_00_rcon: RCOn=%b expected 1", RCOn); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h01) $display("FAIL up_01: Q=%h expected %h", Q, 8'h01); else pass_cnt++;
        CTENn = 1'b1;
    endtask

    task automatic test_down_borrow();
        LOADn = 1'b0; CTENn = 1'b1; U_Dn = 1'b1; LD_INPUT = 8'h10;
        tick();
        LOADn = 1'b1; CTENn = 1'b0;
        tick();
        total_cnt++; if (Q !== 8'h09) $display("FAIL dn_09: Q=%h expected %h", Q, 8'h09); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h08) $display("FAIL dn_08: Q=%h expected %h", Q, 8'h08); else pass_cnt++;
        LOADn = 1'b0; LD_INPUT = 8'h00;
        tick();
        LOADn = 1'b1;
        #1;
        total_cnt++; if (Q !== 8'h00) $display("FAIL dn_load00: Q=%h expected %h", Q, 8'h00); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b0) $display("FAIL dn_00_rcon: RCOn=%b expected 0", RCOn); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h99) $display("FAIL dn_wrap: Q=%h expected %h", Q, 8'h99); else pass_cnt++;
        CTENn = 1'b1;
    endtask

    task automatic test_illegal();
        LOADn = 1'b0; CTENn = 1'b1; U_Dn = 1'b0; LD_INPUT = 8'h0C;
        tick();
        total_cnt++; if (Q !== 8'h0C) $display("FAIL ill_load: Q=%h expected %h", Q, 8'h0C); else pass_cnt++;
        LOADn = 1'b1; CTENn = 1'b0;
        tick();
        total_cnt++; if (Q !== 8'h10) $display("FAIL ill_up: Q=%h expected %h", Q, 8'h10); else pass_cnt++;
        LOADn = 1'b0; CTENn = 1'b1; U_Dn = 1'b1; LD_INPUT = 8'h0C;
        tick();
        LOADn = 1'b1; CTENn = 1'b0;
        tick();
        total_cnt++; if (Q !== 8'h09) $display("FAIL ill_dn: Q=%h expected %h", Q, 8'h09); else pass_cnt++;
        LOADn = 1'b0; CTENn = 1'b1; U_Dn = 1'b0; LD_INPUT = 8'h9C;
        tick();
        LOADn = 1'b1; CTENn = 1'b0;
        tick();
        total_cnt++; if (Q !== 8'h00) $display("FAIL ill_up_chain: Q=%h expected %h", Q, 8'h00); else pass_cnt++;
        CTENn = 1'b1;
    endtask

    task automatic test_priority_hold();
        LOADn = 1'b0; CTENn = 1'b0; U_Dn = 1'b0; LD_INPUT = 8'h42;
        tick();
        total_cnt++; if (Q !== 8'h42) $display("FAIL prio_load: Q=%h expected %h", Q, 8'h42); else pass_cnt++;
        LOADn = 1'b1; CTENn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (Q !== 8'h42) $display("FAIL hold_%0d: Q=%h expected %h", i, Q, 8'h42); else pass_cnt++;
        end
        LOADn = 1'b0; LD_INPUT = 8'h99;
        tick();
        LOADn = 1'b1;
        #1;
        total_cnt++; if (MAX_MIN !== 1'b1) $display("FAIL hold99_maxmin: MAX_MIN=%b expected 1", MAX_MIN); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b1) $display("FAIL hold99_rcon: RCOn=%b expected 1", RCOn); else pass_cnt++;
        CTENn = 1'b0;
        #1;
        total_cnt++; if (RCOn !== 1'b0) $display("FAIL en99_rcon: RCOn=%b expected 0", RCOn); else pass_cnt++;
        U_Dn = 1'b1;
        #1;
        total_cnt++; if (MAX_MIN !== 1'b0) $display("FAIL dn99_maxmin: MAX_MIN=%b expected 0", MAX_MIN); else pass_cnt++;
        total_cnt++; if (RCOn !== 1'b1) $display("FAIL dn99_rcon: RCOn=%b expected 1", RCOn); else pass_cnt++;
        CTENn = 1'b1;
    endtask

    task automatic test_direction_change();
        LOADn = 1'b0; CTENn = 1'b1; LD_INPUT = 8'h42;
        tick();
        LOADn = 1'b1; CTENn = 1'b0; U_Dn = 1'b0;
        tick();
        total_cnt++; if (Q !== 8'h43) $display("FAIL dir_up: Q=%h expected %h", Q, 8'h43); else pass_cnt++;
        U_Dn = 1'b1;
        tick();
        total_cnt++; if (Q !== 8'h42) $display("FAIL dir_dn1: Q=%h expected %h", Q, 8'h42); else pass_cnt++;
        tick();
        total_cnt++; if (Q !== 8'h41) $display("FAIL dir_dn2: Q=%h expected %h", Q, 8'h41); else pass_cnt++;
        CTENn = 1'b1;
    endtask

    task automatic test_cascade();
        c_loadn = 1'b0;
        tick();
        c_loadn = 1'b1; c_ctenn = 1'b0;
        repeat (9) tick();
        total_cnt++; if ({c_hi_q, c_lo_q} !== 8'h09) $display("FAIL cas_09: Q=%h expected %h", {c_hi_q, c_lo_q}, 8'h09); else pass_cnt++;
        total_cnt++; if (c_lo_rco !== 1'b0) $display("FAIL cas_09_rco: RCOn=%b expected 0", c_lo_rco); else pass_cnt++;
        tick();
        total_cnt++; if ({c_hi_q, c_lo_q} !== 8'h10) $display("FAIL cas_10: Q=%h expected %h", {c_hi_q, c_lo_q}, 8'h10); else pass_cnt++;
        repeat (89) tick();
        total_cnt++; if ({c_hi_q, c_lo_q} !== 8'h99) $display("FAIL cas_99: Q=%h expected %h", {c_hi_q, c_lo_q}, 8'h99); else pass_cnt++;
        total_cnt++; if (c_hi_rco !== 1'b0) $display("FAIL cas_99_rco: RCOn=%b expected 0", c_hi_rco); else pass_cnt++;
        total_cnt++; if (c_hi_mm !== 1'b1) $display("FAIL cas_99_mm: MAX_MIN=%b expected 1", c_hi_mm); else pass_cnt++;
        total_cnt++; if ((c_lo_match | c_hi_match) !== 1'b0) $display("FAIL cas_match: MATCH=%b expected 0", c_lo_match | c_hi_match); else pass_cnt++;
        tick();
        total_cnt++; if ({c_hi_q, c_lo_q} !== 8'h00) $display("FAIL cas_wrap: Q=%h expected %h", {c_hi_q, c_lo_q}, 8'h00); else pass_cnt++;
        c_ctenn = 1'b1;
    endtask

    task automatic test_match();
        logic [7:0] seq [5];
        logic       exp_m;
        seq = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h37};
        CMP_VAL = 8'h37;
        LOADn = 1'b0; CTENn = 1'b1; U_Dn = 1'b0; LD_INPUT = 8'h35;
        tick();
        LOADn = 1'b1; CTENn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) U_Dn = 1'b1;
            #1;
            exp_m = MATCH_EN && (seq[i] == 8'h37);
            total_cnt++; if (Q !== seq[i]) $display("FAIL match_q_%0d: Q=%h expected %h", i, Q, seq[i]); else pass_cnt++;
            total_cnt++; if (MATCH !== exp_m) $display("FAIL match_%0d: MATCH=%b expected %b", i, MATCH, exp_m); else pass_cnt++;
            if (i < 4) tick();
        end
        CTENn = 1'b1;
    endtask

    initial begin
        RSTn = 1'b0; LOADn = 1'b1; CTENn = 1'b1; U_Dn = 1'b0;
        LD_INPUT = 8'h00; CMP_VAL = 8'h00;
        c_loadn = 1'b1; c_ctenn = 1'b1;
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_illegal();
        test_priority_hold();
        test_direction_change();
        test_cascade();
        test_match();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
